// File: rtl/serializer_piso_pkg.sv
// Shared types and helpers for the PISO serializer slice.
package serializer_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } serializer_state_t;

    // Width of the bit-index counter for a word of n bits.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serializer_piso_if.sv
// Parallel-in and serial-out val/rdy channels of the serializer.
interface serializer_piso_if #(
    parameter int unsigned nbits = 8
);
    logic             in_val;
    logic             in_rdy;
    logic [nbits-1:0] in_msg;
    logic             out_val;
    logic             out_rdy;
    logic             out_bit;
    logic             out_last;

    // Driver/sink side: produces words, consumes bits.
    modport master (
        output in_val, in_msg, out_rdy,
        input  in_rdy, out_val, out_bit, out_last
    );

    // Serializer side.
    modport slave (
        input  in_val, in_msg, out_rdy,
        output in_rdy, out_val, out_bit, out_last
    );
endinterface

// File: rtl/serializer_piso_reg_en_rst.sv
// Enabled register with asynchronous active-high reset to a fixed value.
module reg_en_rst #(
    parameter int unsigned      nbits   = 1,
    parameter logic [nbits-1:0] rst_val = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [nbits-1:0] d,
    output logic [nbits-1:0] q
);

    // Load d on enabled edges; reset overrides asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= rst_val;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/serializer_piso.sv
// Parallel-in/serial-out serializer: accepts a word, emits it LSB first,
// one bit per accepted output transfer, flagging the final bit.
module serializer_piso
    import serializer_pkg::*;
#(
    parameter int unsigned nbits = 8
) (
    input  logic              clk,
    input  logic              rst,
    serializer_piso_if.slave  bus
);

    localparam int unsigned     CW       = cnt_width(nbits);
    localparam logic [CW-1:0]   LAST_IDX = CW'(nbits - 1);

    serializer_state_t state_q, state_d;
    logic [0:0]        state_bits_q, state_bits_d;
    logic              state_en;

    logic [nbits-1:0]  shreg_q, shreg_d;
    logic              shreg_en;

    logic [CW-1:0]     cnt_q, cnt_d;
    logic              cnt_en;

    logic              in_rdy, out_val, out_bit, out_last;
    logic              in_fire, out_fire;

    reg_en_rst #(.nbits(1), .rst_val(1'b0)) u_state (
        .clk (clk), .rst (rst), .en (state_en), .d (state_bits_d), .q (state_bits_q)
    );

    reg_en_rst #(.nbits(nbits), .rst_val('0)) u_shreg (
        .clk (clk), .rst (rst), .en (shreg_en), .d (shreg_d), .q (shreg_q)
    );

    reg_en_rst #(.nbits(CW), .rst_val('0)) u_cnt (
        .clk (clk), .rst (rst), .en (cnt_en), .d (cnt_d), .q (cnt_q)
    );

    // Map the raw state flop to the enum and back.
    always_comb begin
        state_q      = serializer_state_t'(state_bits_q);
        state_bits_d = state_d;
    end

    // Output decode from registered state; reset only suppresses in_rdy.
    always_comb begin
        in_rdy   = (state_q == IDLE) && !rst;
        out_val  = (state_q == SHIFT);
        out_bit  = out_val && shreg_q[0];
        out_last = out_val && (cnt_q == LAST_IDX);
    end

    // Next-state and datapath update enables.
    always_comb begin
        in_fire  = bus.in_val && in_rdy;
        out_fire = out_val && bus.out_rdy;

        state_en = in_fire || (out_fire && out_last);
        state_d  = in_fire ? SHIFT : IDLE;

        shreg_en = in_fire || (out_fire && !out_last);
        shreg_d  = in_fire ? bus.in_msg : {1'b0, shreg_q[nbits-1:1]};

        cnt_en   = shreg_en;
        cnt_d    = in_fire ? '0 : cnt_q + 1'b1;
    end

    assign bus.in_rdy   = in_rdy;
    assign bus.out_val  = out_val;
    assign bus.out_bit  = out_bit;
    assign bus.out_last = out_last;

endmodule
